// File: rtl/pipe_redirect_ctrl.sv
// Pipeline sequencer: arbitrates redirect sources, defers redirects behind busy
// data-memory accesses, and drives per-stage stall/flush plus perf counters.
module pipe_redirect_ctrl #(
    parameter int PC_WIDTH      = 32,
    parameter int CNT_WIDTH     = 32,
    parameter int REFILL_CYCLES = 2
) (
    input  logic                 clk,
    input  logic                 resetn,
    input  logic                 exception_valid,
    input  logic [PC_WIDTH-1:0]  pcexception,
    input  logic                 is_eret,
    input  logic [PC_WIDTH-1:0]  epc,
    input  logic                 branch_taken,
    input  logic [PC_WIDTH-1:0]  pcbranch,
    input  logic                 rob_full,
    input  logic                 mem_busy,
    output logic                 stallF,
    output logic                 stallD,
    output logic                 stallR,
    output logic                 stallI,
    output logic                 stallE,
    output logic                 stallC,
    output logic                 flushD,
    output logic                 flushR,
    output logic                 flushI,
    output logic                 flushE,
    output logic                 flushC,
    output logic                 redirect_valid,
    output logic [PC_WIDTH-1:0]  redirect_pc,
    output logic [CNT_WIDTH-1:0] stall_cycles,
    output logic [CNT_WIDTH-1:0] redirect_count
);

    typedef enum logic [1:0] {S_IDLE, S_WAIT_MEM, S_REDIRECT, S_REFILL} state_t;

    localparam int RW = (REFILL_CYCLES > 1) ? $clog2(REFILL_CYCLES) : 1;

    state_t                r_state, w_state_nxt;
    logic [PC_WIDTH-1:0]   r_pc, w_pc_nxt;
    logic [PC_WIDTH-1:0]   r_last_pc;
    logic [1:0]            r_kind, w_kind_nxt;
    logic [RW-1:0]         r_refill, w_refill_nxt;
    logic [CNT_WIDTH-1:0]  r_stall_cycles, r_redirect_count;

    logic [1:0]            w_ev_kind;
    logic [PC_WIDTH-1:0]   w_ev_pc;
    logic                  w_stall_all, w_stall_fe, w_flush, w_redirect, w_any_stall;

    // Kind doubles as priority: exception(3) > eret(2) > branch(1), 0 = none.
    always_comb begin
        w_ev_kind = 2'd0;
        w_ev_pc   = '0;
        if (exception_valid) begin
            w_ev_kind = 2'd3;
            w_ev_pc   = pcexception;
        end else if (is_eret) begin
            w_ev_kind = 2'd2;
            w_ev_pc   = epc;
        end else if (branch_taken) begin
            w_ev_kind = 2'd1;
            w_ev_pc   = pcbranch;
        end
    end

    always_comb begin
        w_state_nxt  = r_state;
        w_pc_nxt     = r_pc;
        w_kind_nxt   = r_kind;
        w_refill_nxt = r_refill;
        w_stall_all  = 1'b0;
        w_stall_fe   = 1'b0;
        w_flush      = 1'b0;
        w_redirect   = 1'b0;
        case (r_state)
            S_IDLE, S_REFILL: begin
                // Frontend is empty during refill, so a full ROB cannot back up into it.
                if (mem_busy)
                    w_stall_all = 1'b1;
                else if (rob_full && r_state == S_IDLE)
                    w_stall_fe = 1'b1;
                if (w_ev_kind != 2'd0) begin
                    w_pc_nxt    = w_ev_pc;
                    w_kind_nxt  = w_ev_kind;
                    w_state_nxt = mem_busy ? S_WAIT_MEM : S_REDIRECT;
                end else if (r_state == S_REFILL) begin
                    if (r_refill == '0)
                        w_state_nxt = S_IDLE;
                    else
                        w_refill_nxt = r_refill - RW'(1);
                end
            end
            S_WAIT_MEM: begin
                w_stall_all = 1'b1;
                if (w_ev_kind > r_kind) begin
                    w_pc_nxt   = w_ev_pc;
                    w_kind_nxt = w_ev_kind;
                end
                if (!mem_busy)
                    w_state_nxt = S_REDIRECT;
            end
            S_REDIRECT: begin
                // Events seen now come from squashed instructions and are dropped.
                w_flush    = 1'b1;
                w_redirect = 1'b1;
                if (REFILL_CYCLES == 0) begin
                    w_state_nxt = S_IDLE;
                end else begin
                    w_state_nxt  = S_REFILL;
                    w_refill_nxt = RW'(REFILL_CYCLES - 1);
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    assign w_any_stall = w_stall_all | w_stall_fe;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_state          <= S_IDLE;
            r_pc             <= '0;
            r_kind           <= 2'd0;
            r_last_pc        <= '0;
            r_refill         <= '0;
            r_stall_cycles   <= '0;
            r_redirect_count <= '0;
        end else begin
            r_state  <= w_state_nxt;
            r_pc     <= w_pc_nxt;
            r_kind   <= w_kind_nxt;
            r_refill <= w_refill_nxt;
            if (w_redirect) begin
                r_last_pc        <= r_pc;
                r_redirect_count <= r_redirect_count + CNT_WIDTH'(1);
            end
            if (w_any_stall)
                r_stall_cycles <= r_stall_cycles + CNT_WIDTH'(1);
        end
    end

    // Outputs are forced low while reset is asserted, even with mem_busy high.
    assign stallF = resetn & w_any_stall;
    assign stallD = resetn & w_any_stall;
    assign stallR = resetn & w_any_stall;
    assign stallI = resetn & w_stall_all;
    assign stallE = resetn & w_stall_all;
    assign stallC = resetn & w_stall_all;

    assign flushD = resetn & w_flush;
    assign flushR = resetn & w_flush;
    assign flushI = resetn & w_flush;
    assign flushE = resetn & w_flush;
    assign flushC = resetn & w_flush;

    assign redirect_valid = resetn & w_redirect;
    assign redirect_pc    = (r_state == S_REDIRECT) ? r_pc : r_last_pc;
    assign stall_cycles   = r_stall_cycles;
    assign redirect_count = r_redirect_count;

endmodule

// File: tb/tb_pipe_redirect_ctrl.sv
// Scoreboard bench for pipe_redirect_ctrl: expected redirects queued at stimulus
// time and matched when redirect_valid fires; stalls/flushes checked per cycle.
module tb_pipe_redirect_ctrl;

    logic        clk = 1'b0;
    logic        resetn = 1'b0;
    logic        exception_valid = 1'b0, is_eret = 1'b0, branch_taken = 1'b0;
    logic [31:0] pcexception = '0, epc = '0, pcbranch = '0;
    logic        rob_full = 1'b0, mem_busy = 1'b0;
    logic        stallF, stallD, stallR, stallI, stallE, stallC;
    logic        flushD, flushR, flushI, flushE, flushC;
    logic        redirect_valid;
    logic [31:0] redirect_pc, stall_cycles, redirect_count;

    pipe_redirect_ctrl #(.PC_WIDTH(32), .CNT_WIDTH(32), .REFILL_CYCLES(2)) dut (
        .clk(clk), .resetn(resetn),
        .exception_valid(exception_valid), .pcexception(pcexception),
        .is_eret(is_eret), .epc(epc),
        .branch_taken(branch_taken), .pcbranch(pcbranch),
        .rob_full(rob_full), .mem_busy(mem_busy),
        .stallF(stallF), .stallD(stallD), .stallR(stallR),
        .stallI(stallI), .stallE(stallE), .stallC(stallC),
        .flushD(flushD), .flushR(flushR), .flushI(flushI),
        .flushE(flushE), .flushC(flushC),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .stall_cycles(stall_cycles), .redirect_count(redirect_count)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc++;

    typedef struct { logic [31:0] pc; int at; } exp_t;
    exp_t q[$];
    exp_t m_e;

    int n_checks = 0, n_errors = 0, exp_sc = 0, n_push = 0;

    wire [5:0] w_st = {stallF, stallD, stallR, stallI, stallE, stallC};
    wire [4:0] w_fl = {flushD, flushR, flushI, flushE, flushC};

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic nxt;
        @(posedge clk);
        #1;
    endtask

    // Check one cycle's combinational stall/flush outputs and the running stall count.
    task automatic cyc_chk(input string tag, input logic [5:0] est, input logic [4:0] efl);
        @(negedge clk);
        check({tag, "_stall"}, w_st, est);
        check({tag, "_flush"}, w_fl, efl);
        check({tag, "_scnt"}, stall_cycles, exp_sc);
        if (est != 6'd0) exp_sc++;
        nxt();
    endtask

    task automatic expect_redir(input logic [31:0] pc, input int at);
        q.push_back('{pc, at});
        n_push++;
    endtask

    always @(negedge clk) begin
        if (resetn) begin
            if (q.size() != 0 && q[0].at == cyc) begin
                m_e = q.pop_front();
                check("redir_valid", redirect_valid, 1'b1);
                check("redir_pc", redirect_pc, m_e.pc);
            end else if (redirect_valid) begin
                check("spurious_redir", redirect_valid, 1'b0);
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        mem_busy = 1'b1;
        nxt(); nxt();
        check("rst_stall", w_st, 6'd0);
        check("rst_flush", w_fl, 5'd0);
        check("rst_rv", redirect_valid, 1'b0);
        check("rst_pc", redirect_pc, 32'd0);
        check("rst_cnt", {stall_cycles, redirect_count}, 64'd0);
        resetn = 1'b1; mem_busy = 1'b0;
        cyc_chk("idle", 6'h00, 5'h00);
        mem_busy = 1'b1;
        cyc_chk("busy", 6'h3F, 5'h00);
        mem_busy = 1'b0; rob_full = 1'b1;
        cyc_chk("robfull", 6'h38, 5'h00);
        rob_full = 1'b0;

        // Branch with memory idle: redirect the very next cycle.
        branch_taken = 1'b1; pcbranch = 32'hBFC0_0100;
        expect_redir(32'hBFC0_0100, cyc + 1);
        cyc_chk("br_ev", 6'h00, 5'h00);
        branch_taken = 1'b0; pcbranch = '0;
        cyc_chk("br_redir", 6'h00, 5'h1F);
        cyc_chk("br_refill", 6'h00, 5'h00);
        check("hold_pc", redirect_pc, 32'hBFC0_0100);
        check("rcnt1", redirect_count, 32'd1);
        cyc_chk("br_refill2", 6'h00, 5'h00);
        cyc_chk("br_idle", 6'h00, 5'h00);

        // All three sources at once; then a branch pulse during REDIRECT is dropped.
        exception_valid = 1'b1; pcexception = 32'hBFC0_0380;
        is_eret = 1'b1; epc = 32'h8000_1000;
        branch_taken = 1'b1; pcbranch = 32'hBFC0_0100;
        expect_redir(32'hBFC0_0380, cyc + 1);
        cyc_chk("pri_ev", 6'h00, 5'h00);
        exception_valid = 1'b0; is_eret = 1'b0; pcbranch = 32'h1111_2220;
        cyc_chk("pri_redir", 6'h00, 5'h1F);
        branch_taken = 1'b0;
        cyc_chk("pri_refill", 6'h00, 5'h00);
        cyc_chk("pri_refill2", 6'h00, 5'h00);
        cyc_chk("pri_idle", 6'h00, 5'h00);

        // Deferred redirect: eret latched, branch ignored, exception overwrites, eret ignored.
        mem_busy = 1'b1; is_eret = 1'b1; epc = 32'h8000_1000;
        cyc_chk("wm_ev", 6'h3F, 5'h00);
        is_eret = 1'b0; branch_taken = 1'b1; pcbranch = 32'h2222_0000;
        cyc_chk("wm1", 6'h3F, 5'h00);
        branch_taken = 1'b0; exception_valid = 1'b1; pcexception = 32'hBFC0_0380;
        cyc_chk("wm2", 6'h3F, 5'h00);
        exception_valid = 1'b0; is_eret = 1'b1; epc = 32'h3333_0000;
        cyc_chk("wm3", 6'h3F, 5'h00);
        is_eret = 1'b0; mem_busy = 1'b0;
        expect_redir(32'hBFC0_0380, cyc + 1);
        cyc_chk("wm_fall", 6'h3F, 5'h00);
        cyc_chk("wm_redir", 6'h00, 5'h1F);
        cyc_chk("wm_refill", 6'h00, 5'h00);
        cyc_chk("wm_refill2", 6'h00, 5'h00);
        cyc_chk("wm_idle", 6'h00, 5'h00);

        // rob_full held across redirect: suppressed during refill only.
        branch_taken = 1'b1; pcbranch = 32'h0040_0000;
        expect_redir(32'h0040_0000, cyc + 1);
        cyc_chk("rf_ev", 6'h00, 5'h00);
        branch_taken = 1'b0; rob_full = 1'b1;
        cyc_chk("rf_redir", 6'h00, 5'h1F);
        cyc_chk("rf_sup1", 6'h00, 5'h00);
        cyc_chk("rf_sup2", 6'h00, 5'h00);
        cyc_chk("rf_stall1", 6'h38, 5'h00);
        cyc_chk("rf_stall2", 6'h38, 5'h00);
        rob_full = 1'b0;
        cyc_chk("rf_idle", 6'h00, 5'h00);
        check("rcnt_all", redirect_count, n_push);
        check("q_empty", q.size(), 0);

        // Reset asserted in WAIT_MEM.
        mem_busy = 1'b1; is_eret = 1'b1; epc = 32'h8000_1000;
        cyc_chk("rs_ev", 6'h3F, 5'h00);
        is_eret = 1'b0;
        cyc_chk("rs_wait", 6'h3F, 5'h00);
        resetn = 1'b0;
        #1;
        check("rs_stall", w_st, 6'd0);
        check("rs_flush", w_fl, 5'd0);
        check("rs_rv", redirect_valid, 1'b0);
        check("rs_pc", redirect_pc, 32'd0);
        check("rs_scnt", stall_cycles, 32'd0);
        check("rs_rcnt", redirect_count, 32'd0);
        exp_sc = 0; mem_busy = 1'b0;
        nxt();
        resetn = 1'b1;
        cyc_chk("rs_idle", 6'h00, 5'h00);
        cyc_chk("rs_idle2", 6'h00, 5'h00);

        branch_taken = 1'b1; pcbranch = 32'h0000_0ABC;
        expect_redir(32'h0000_0ABC, cyc + 1);
        cyc_chk("post_ev", 6'h00, 5'h00);
        branch_taken = 1'b0;
        cyc_chk("post_redir", 6'h00, 5'h1F);
        check("rcnt_post", redirect_count, 32'd1);
        check("q_final", q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/pipe_redirect_ctrl.md
Name: pipe_redirect_ctrl

Overview:
Central pipeline sequencer for the out-of-order core: generates stallF..stallC / flushD..flushC for all pipeline registers. It arbitrates between redirect sources (exception, eret, ROB branch mispredict) and emits a single registered redirect PC to pcselect. If a redirect arrives while the data-memory port is busy, the block holds the redirect pending until the access completes. It also keeps stall/flush performance counters.

Parameters:
PC_WIDTH, 32, width of word_t / redirect PCs
CNT_WIDTH, 32, width of performance counters
REFILL_CYCLES, 2, cycles after a redirect during which rob_full-induced stalls are ignored (frontend empty)

Ports:
clk  input  1  core clock
resetn  input  1  asynchronous active-low reset
exception_valid  input  1  exception detected at commit
pcexception  input  32  exception vector
is_eret  input  1  eret committing
epc  input  32  return PC from cp0
branch_taken  input  1  ROB resolved mispredicted/taken branch
pcbranch  input  32  branch target
rob_full  input  1  ROB cannot accept new entries
mem_busy  input  1  outstanding data-memory access, cannot be cancelled
stallF, stallD, stallR, stallI, stallE, stallC  output  1 each  pipeline register stalls
flushD, flushR, flushI, flushE, flushC  output  1 each  pipeline register flushes
redirect_valid  output  1  one-cycle pulse, pcselect takes redirect_pc
redirect_pc  output  32  redirect target
stall_cycles  output  CNT_WIDTH  cycles with any stall asserted
redirect_count  output  CNT_WIDTH  redirects issued

Behaviour:
- Reset (resetn low, async): state=IDLE; all stalls, flushes and redirect_valid=0; redirect_pc=0; counters=0; pending cleared; refill counter=0.
- Priority of a same-cycle event: exception > eret > branch. Selected PC: pcexception / epc / pcbranch.
- States: IDLE, WAIT_MEM, REDIRECT, REFILL.
- IDLE, no event: stalls combinational from the inputs. mem_busy -> all six stalls=1. Otherwise rob_full -> stallF, stallD, stallR=1. Flushes=0.
- IDLE, event, mem_busy=0: latch {pc, kind}; next state REDIRECT.
- IDLE, event, mem_busy=1: latch; next WAIT_MEM.
- Latency: redirect issues exactly 1 cycle after the event cycle when memory is idle.
- WAIT_MEM: all stalls=1, flushes=0.
  - A new event of strictly higher priority overwrites the latch. Equal or lower priority events are ignored.
  - When mem_busy is sampled 0, next state is REDIRECT.
- REDIRECT (one cycle):
  - redirect_valid=1, redirect_pc=latched pc.
  - All flushD..flushC=1 and all stalls=0. Flush wins over any stall input.
  - redirect_count += 1.
  - Events sampled in this cycle are dropped: they belong to squashed instructions.
  - Next state REFILL with refill counter=REFILL_CYCLES-1. If REFILL_CYCLES=0, next state is IDLE.
- REFILL:
  - Behaves as IDLE for mem_busy and events. An event exits to REDIRECT or WAIT_MEM.
  - rob_full stalls are suppressed.
  - Counter decrements each cycle; at 0 the next state is IDLE.
- redirect_pc holds its last value when redirect_valid=0.
- stall_cycles increments on every cycle where any stall output=1. Both counters wrap modulo 2^CNT_WIDTH.
- All state and counter registers update on posedge clk. Stall/flush/redirect outputs are combinational from state plus current inputs.

Test Plan:
- Reset mid-operation: resetn low during WAIT_MEM -> all outputs 0 immediately, state IDLE, counters 0.
- Branch with mem idle:
  - branch_taken=1, pcbranch=0xBFC0_0100 in cycle N.
  - Cycle N+1: redirect_valid=1, redirect_pc=0xBFC0_0100, all flushes=1, stalls=0.
  - redirect_count=1.
- Simultaneous exception and branch: exception_valid=1 (pcexception=0xBFC0_0380) with branch_taken=1 -> redirect_pc=0xBFC0_0380.
- Deferred redirect with overwrite:
  - mem_busy=1 for 4 cycles; eret (epc=0x8000_1000) arrives, then an exception 2 cycles later.
  - All stalls=1 throughout WAIT_MEM.
  - Single redirect to pcexception the cycle after mem_busy falls; redirect_count += 1 only.
- Event in REDIRECT dropped: branch_taken pulses during the REDIRECT cycle -> no second redirect.
- Refill suppression: rob_full=1 held through redirect, REFILL_CYCLES=2 -> stallF=0 for 2 cycles after REDIRECT, then stallF=stallD=stallR=1; stall_cycles counts only those later cycles.
